// File: rtl/dffram_port_arbiter.sv
// Two-requester front end for the single-port management DFFRAM: the SoC port
// normally wins, and a bounded-wait counter forces housekeeping reads through.
module dffram_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int HK_MAX_WAIT = 4
) (
    input  logic          core_clk,
    input  logic          core_rstn,
    input  logic          soc_en,
    input  logic [3:0]    soc_we,
    input  logic [AW-1:0] soc_a,
    input  logic [DW-1:0] soc_di,
    output logic [DW-1:0] soc_do,
    output logic          soc_ready,
    input  logic          ro_req,
    input  logic [AW-1:0] ro_addr,
    output logic          ro_busy,
    output logic [DW-1:0] ro_data,
    output logic          ro_valid,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    localparam int CW = (HK_MAX_WAIT > 0) ? $clog2(HK_MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(HK_MAX_WAIT);

    logic          pend_q,      pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [CW-1:0] wait_cnt_q,  wait_cnt_d;
    logic          hk_rd_q,     hk_rd_d;
    logic [DW-1:0] ro_data_q,   ro_data_d;
    logic          ro_valid_q,  ro_valid_d;
    logic          grant_hk;

    always_comb begin
        grant_hk    = pend_q & (~soc_en | (wait_cnt_q == MAX_CNT));
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        wait_cnt_d  = wait_cnt_q;
        // hk_rd marks the cycle in which ram_do holds the housekeeping word
        hk_rd_d     = grant_hk;
        ro_valid_d  = hk_rd_q;
        ro_data_d   = hk_rd_q ? ram_do : ro_data_q;

        if (grant_hk) begin
            pend_d     = 1'b0;
            wait_cnt_d = '0;
        end else if (pend_q) begin
            if (soc_en && (wait_cnt_q != MAX_CNT))
                wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
            if (ro_req) begin
                pend_d      = 1'b1;
                pend_addr_d = ro_addr;
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wait_cnt_q  <= '0;
            hk_rd_q     <= 1'b0;
            ro_data_q   <= '0;
            ro_valid_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wait_cnt_q  <= wait_cnt_d;
            hk_rd_q     <= hk_rd_d;
            ro_data_q   <= ro_data_d;
            ro_valid_q  <= ro_valid_d;
        end
    end

    // Housekeeping path is read-only; a stalled SoC request must be re-presented.
    always_comb begin
        if (grant_hk) begin
            ram_en    = 1'b1;
            ram_we    = 4'b0000;
            ram_a     = pend_addr_q;
            soc_ready = 1'b0;
        end else begin
            ram_en    = soc_en;
            ram_we    = soc_we;
            ram_a     = soc_a;
            soc_ready = 1'b1;
        end
    end

    assign ram_di   = soc_di;
    assign soc_do   = ram_do;
    assign ro_busy  = pend_q;
    assign ro_data  = ro_data_q;
    assign ro_valid = ro_valid_q;

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// Directed bench for dffram_port_arbiter: a default build and an HK_MAX_WAIT=0
// build, each driving a small behavioural DFFRAM model.
module tb_dffram_port_arbiter;

    logic clk = 1'b0;
    logic core_rstn = 1'b0;
    always #5 clk = ~clk;

    // instance A: HK_MAX_WAIT = 4
    logic        soc_en, ro_req, soc_ready, ro_busy, ro_valid, ram_en;
    logic [3:0]  soc_we, ram_we;
    logic [7:0]  soc_a, ro_addr, ram_a;
    logic [31:0] soc_di, soc_do, ro_data, ram_di, ram_do;
    // instance B: HK_MAX_WAIT = 0
    logic        b_soc_en, b_ro_req, b_soc_ready, b_ro_busy, b_ro_valid, b_ram_en;
    logic [3:0]  b_soc_we, b_ram_we;
    logic [7:0]  b_soc_a, b_ro_addr, b_ram_a;
    logic [31:0] b_soc_di, b_soc_do, b_ro_data, b_ram_di, b_ram_do;

    dffram_port_arbiter #(.AW(8), .DW(32), .HK_MAX_WAIT(4)) dut_a (
        .core_clk(clk), .core_rstn(core_rstn),
        .soc_en(soc_en), .soc_we(soc_we), .soc_a(soc_a), .soc_di(soc_di),
        .soc_do(soc_do), .soc_ready(soc_ready),
        .ro_req(ro_req), .ro_addr(ro_addr), .ro_busy(ro_busy),
        .ro_data(ro_data), .ro_valid(ro_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_do(ram_do)
    );

    dffram_port_arbiter #(.AW(8), .DW(32), .HK_MAX_WAIT(0)) dut_b (
        .core_clk(clk), .core_rstn(core_rstn),
        .soc_en(b_soc_en), .soc_we(b_soc_we), .soc_a(b_soc_a), .soc_di(b_soc_di),
        .soc_do(b_soc_do), .soc_ready(b_soc_ready),
        .ro_req(b_ro_req), .ro_addr(b_ro_addr), .ro_busy(b_ro_busy),
        .ro_data(b_ro_data), .ro_valid(b_ro_valid),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_a(b_ram_a), .ram_di(b_ram_di),
        .ram_do(b_ram_do)
    );

    // behavioural DFFRAMs: byte-write, Do updated on every enabled access
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem_a[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
            ram_do <= mem_a[ram_a];
        end
        if (b_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (b_ram_we[b]) mem_b[b_ram_a][b*8 +: 8] <= b_ram_di[b*8 +: 8];
            b_ram_do <= mem_b[b_ram_a];
        end
    end

    int checks = 0;
    int errors = 0;
    int valid_a = 0;
    int valid_b = 0;
    logic [31:0] exp_q_a [$];
    logic [31:0] exp_q_b [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // advance one edge, then score any ro_valid pulse against the queues
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (ro_valid === 1'b1) begin
            valid_a++;
            if (exp_q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = exp_q_a.pop_front();
                check("a_ro_data", ro_data, e);
            end
        end
        if (b_ro_valid === 1'b1) begin
            valid_b++;
            if (exp_q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = exp_q_b.pop_front();
                check("b_ro_data", b_ro_data, e);
            end
        end
    endtask

    task automatic soc_write(input logic [7:0] a, input logic [31:0] d);
        soc_en = 1'b1; soc_we = 4'hF; soc_a = a; soc_di = d;
        tick();
        soc_en = 1'b0; soc_we = 4'h0;
    endtask

    initial begin
        int v0;
        soc_en = 0; soc_we = 0; soc_a = 0; soc_di = 0; ro_req = 0; ro_addr = 0;
        b_soc_en = 0; b_soc_we = 0; b_soc_a = 0; b_soc_di = 0; b_ro_req = 0; b_ro_addr = 0;

        // reset state
        #3;
        check("rst_ro_busy", {31'd0, ro_busy}, 32'd0);
        check("rst_ro_valid", {31'd0, ro_valid}, 32'd0);
        check("rst_ro_data", ro_data, 32'd0);
        check("rst_soc_ready", {31'd0, soc_ready}, 32'd1);
        soc_en = 1'b1; #1;
        check("rst_ram_en_follows", {31'd0, ram_en}, 32'd1);
        soc_en = 1'b0;
        @(negedge clk); core_rstn = 1'b1;
        tick();

        soc_write(8'h12, 32'hDEADBEEF);
        soc_write(8'h20, 32'h11223344);
        soc_write(8'h30, 32'hCAFEF00D);
        soc_write(8'h40, 32'h12345678);
        b_soc_en = 1'b1; b_soc_we = 4'hF; b_soc_a = 8'h05; b_soc_di = 32'h0BADF00D;
        soc_en = 1'b1; soc_a = 8'h12;
        tick();
        b_soc_en = 1'b0; b_soc_we = 4'h0; soc_en = 1'b0;
        check("soc_read_do", soc_do, 32'hDEADBEEF);

        // 1: idle RAM, single housekeeping read
        ro_req = 1'b1; ro_addr = 8'h12; exp_q_a.push_back(32'hDEADBEEF);
        #1 check("t1_ready_before", {31'd0, soc_ready}, 32'd1);
        tick();
        ro_req = 1'b0; ro_addr = 8'h00;
        check("t1_busy", {31'd0, ro_busy}, 32'd1);
        check("t1_ram_en", {31'd0, ram_en}, 32'd1);
        check("t1_ram_a", {24'd0, ram_a}, 32'h12);
        check("t1_ram_we", {28'd0, ram_we}, 32'd0);
        v0 = valid_a;
        tick();
        check("t1_busy_clear", {31'd0, ro_busy}, 32'd0);
        check("t1_no_early_valid", {31'd0, ro_valid}, 32'd0);
        tick();
        check("t1_valid_now", {31'd0, ro_valid}, 32'd1);
        tick();
        check("t1_valid_one_cycle", {31'd0, ro_valid}, 32'd0);
        check("t1_data_held", ro_data, 32'hDEADBEEF);
        check("t1_pulse_count", valid_a - v0, 32'd1);

        // 2: SoC streams reads; housekeeping forced through after 4 deferrals
        soc_en = 1'b1; soc_we = 4'h0; soc_a = 8'h30;
        ro_req = 1'b1; ro_addr = 8'h40; exp_q_a.push_back(32'h12345678);
        tick();
        ro_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_soc_granted", {31'd0, soc_ready}, 32'd1);
            check("t2_ram_a_soc", {24'd0, ram_a}, 32'h30);
            tick();
        end
        check("t2_soc_stalled", {31'd0, soc_ready}, 32'd0);
        check("t2_ram_a_hk", {24'd0, ram_a}, 32'h40);
        v0 = valid_a;
        tick();
        check("t2_soc_resumes", {31'd0, soc_ready}, 32'd1);
        tick();
        check("t2_valid_pulse", valid_a - v0, 32'd1);

        // 3: SoC byte write preempted, lands on retry
        ro_req = 1'b1; ro_addr = 8'h20; exp_q_a.push_back(32'h11223344);
        tick();
        ro_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        soc_we = 4'b0011; soc_a = 8'h20; soc_di = 32'hAAAA5555;
        #1;
        check("t3_write_stalled", {31'd0, soc_ready}, 32'd0);
        check("t3_hk_no_write", {28'd0, ram_we}, 32'd0);
        tick();
        check("t3_retry_ready", {31'd0, soc_ready}, 32'd1);
        check("t3_retry_we", {28'd0, ram_we}, 32'h3);
        tick();
        soc_en = 1'b0; soc_we = 4'h0;
        tick();
        ro_req = 1'b1; ro_addr = 8'h20; exp_q_a.push_back(32'h11225555);
        tick();
        ro_req = 1'b0;
        tick(); tick();
        check("t3_queue_drained", exp_q_a.size(), 32'd0);

        // 4: second request while busy is ignored
        ro_req = 1'b1; ro_addr = 8'h30; exp_q_a.push_back(32'hCAFEF00D);
        v0 = valid_a;
        tick();
        ro_addr = 8'h40;
        check("t4_busy", {31'd0, ro_busy}, 32'd1);
        tick();
        ro_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t4_single_valid", valid_a - v0, 32'd1);
        check("t4_idle_after", {31'd0, ro_busy}, 32'd0);

        // 5: reset while a read is pending discards it
        soc_en = 1'b1; soc_a = 8'h30;
        ro_req = 1'b1; ro_addr = 8'h12;
        tick();
        ro_req = 1'b0;
        check("t5_pending", {31'd0, ro_busy}, 32'd1);
        #2 core_rstn = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, ro_busy}, 32'd0);
        check("t5_rst_valid", {31'd0, ro_valid}, 32'd0);
        check("t5_rst_data", ro_data, 32'd0);
        v0 = valid_a;
        tick();
        @(negedge clk); core_rstn = 1'b1;
        soc_en = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t5_no_valid_after", valid_a - v0, 32'd0);

        // 6: HK_MAX_WAIT=0 preempts the SoC immediately
        b_soc_en = 1'b1; b_soc_a = 8'h06;
        b_ro_req = 1'b1; b_ro_addr = 8'h05; exp_q_b.push_back(32'h0BADF00D);
        #1 check("t6_ready_before", {31'd0, b_soc_ready}, 32'd1);
        tick();
        b_ro_req = 1'b0;
        check("t6_preempt", {31'd0, b_soc_ready}, 32'd0);
        check("t6_ram_a_hk", {24'd0, b_ram_a}, 32'h05);
        v0 = valid_b;
        tick();
        check("t6_resume", {31'd0, b_soc_ready}, 32'd1);
        check("t6_ram_a_soc", {24'd0, b_ram_a}, 32'h06);
        tick();
        b_soc_en = 1'b0;
        check("t6_valid_pulse", valid_b - v0, 32'd1);

        check("end_queue_a", exp_q_a.size(), 32'd0);
        check("end_queue_b", exp_q_b.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
